// File: rtl/mem_arb_defs.sv
// Shared definitions for the memory port arbiter.
//   state_e : transaction FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_e : which requester owns the in-flight transaction
//   CntW    : width of the fixed-latency countdown counter
//   GntIf / GntD : bit positions in the arbiter's one-hot grant vector
package mem_arb_defs;

  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnIf   = 2'd1,
    OwnD    = 2'd2
  } owner_e;

  localparam int unsigned GntIf = 0;
  localparam int unsigned GntD  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   if_req     : fetch request
//   d_req      : data request
//   last_owner : requester that won the previous arbitration
//   grant      : one-hot grant, bit GntIf = fetch, bit GntD = data (0 when no request)
module rr_arbiter2
  import mem_arb_defs::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  owner_e     last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (if_req && d_req) begin
      // On a tie the requester that did not win last time goes first.
      if (last_owner == OwnIf) begin
        grant[GntD] = 1'b1;
      end else begin
        grant[GntIf] = 1'b1;
      end
    end else if (if_req) begin
      grant[GntIf] = 1'b1;
    end else if (d_req) begin
      grant[GntD] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported, fixed-latency main memory between the instruction-fetch path and
// the load/store data path. One transaction in flight at a time, round-robin on ties.
// Ports:
//   clock, reset_n        : clock (rising edge) and asynchronous active-low reset
//   if_req/if_addr        : fetch request (held until if_gnt) and address
//   if_gnt/if_rvalid      : fetch accepted / fetch data valid (one-cycle pulses)
//   if_rdata              : fetched word, low 32 bits of mem_rdata
//   d_req/d_we/d_addr/d_wdata : data request, store flag, address, store data
//   d_gnt/d_rvalid        : data accepted / load data or store ack valid (one-cycle pulses)
//   d_rdata               : load data, 0 on a store acknowledge
//   mem_en/mem_we/mem_addr/mem_wdata : memory strobe, write strobe, address, write data
//   mem_rdata             : memory read data, valid MEM_LAT cycles after the mem_en cycle
//   busy                  : high whenever a transaction is in flight
// All outputs are registered.
module mem_port_arbiter
  import mem_arb_defs::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned MEM_LAT     = 2,
  parameter bit          FETCH_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
    $error("mem_port_arbiter: MEM_LAT=%0d is outside 1..15", MEM_LAT);
  end

  localparam logic [CntW-1:0] CntLoad  = CntW'(MEM_LAT - 1);
  // The first tie goes to the requester that is not last_owner.
  localparam owner_e          LastInit = FETCH_FIRST ? OwnD : OwnIf;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  owner_e              owner_q, owner_d;
  owner_e              last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                if_gnt_q, if_gnt_d;
  logic                d_gnt_q, d_gnt_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                busy_q, busy_d;

  logic [1:0]          grant;

  rr_arbiter2 u_rr_arbiter2 (
    .if_req     (if_req),
    .d_req      (d_req),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rvalid_d  = 1'b0;
    d_rvalid_d   = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (grant[GntIf]) begin
          owner_d      = OwnIf;
          last_owner_d = OwnIf;
          addr_d       = if_addr;
          we_d         = 1'b0;
          wdata_d      = '0;
          state_d      = StIssue;
        end else if (grant[GntD]) begin
          owner_d      = OwnD;
          last_owner_d = OwnD;
          addr_d       = d_addr;
          we_d         = d_we;
          wdata_d      = d_wdata;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = CntLoad;
        state_d = StWait;
      end
      StWait: begin
        if (cnt_q == '0) begin
          // mem_rdata is valid in this cycle; hand it to the owner at the closing edge.
          state_d = StIdle;
          owner_d = OwnNone;
          if (owner_q == OwnIf) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata[31:0];
          end else if (owner_q == OwnD) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = we_q ? '0 : mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered outputs are derived from the state being entered so they line up with it.
    mem_en_d = (state_d == StIssue);
    mem_we_d = mem_en_d && we_d;
    if_gnt_d = mem_en_d && (owner_d == OwnIf);
    d_gnt_d  = mem_en_d && (owner_d == OwnD);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      owner_q      <= OwnNone;
      last_owner_q <= LastInit;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_gnt_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_gnt_q     <= if_gnt_d;
      d_gnt_q      <= d_gnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign d_rvalid  = d_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  // The latched transaction registers drive the memory port directly.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = busy_q;

endmodule
